// File: rtl/clk_switch_sequencer.sv
// rtl/clk_switch_sequencer.sv - clock-source switch sequencer (optional AUTO_FAILOVER_EN autonomous failover)
module clk_switch_sequencer #(
  parameter int CNT_W          = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DWELL_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 200,
  parameter bit RESET_SEL      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_sel,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_sel,
  output logic       req1_ready,
  input  logic       clk1_ok,
  input  logic       clk2_ok,
  output logic       select,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       resp_id,
  output logic [1:0] err_code
);

  // Counter compare points; the counter restarts at zero on every state entry.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0]       ERR_FAILOVER = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SWITCH,
    S_SETTLE,
    S_DWELL
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             select_n;
  logic             target, target_n;
  logic             id, id_n;
  logic             fo_active, fo_active_n;
  logic             done_n, err_n, resp_id_n;
  logic [1:0]       err_code_n;

  logic             failover_hit;
  logic             grant0, grant1;
  logic             acc_sel, acc_id;
  logic             target_ok;

  // Fixed-priority grant, only while idle and not preempted by a failover.
  assign grant0     = rst && (state == S_IDLE) && !failover_hit && req0_valid;
  assign grant1     = rst && (state == S_IDLE) && !failover_hit && !req0_valid && req1_valid;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign acc_sel    = grant0 ? req0_sel : req1_sel;
  assign acc_id     = grant1;
  assign target_ok  = target ? clk1_ok : clk2_ok;
  assign busy       = (state != S_IDLE);

`ifdef AUTO_FAILOVER_EN
  logic [1:0] low_cnt;
  logic       cur_ok, other_ok, watch;

  assign cur_ok       = select ? clk1_ok : clk2_ok;
  assign other_ok     = select ? clk2_ok : clk1_ok;
  assign watch        = (state == S_IDLE) || (state == S_DWELL);
  assign failover_hit = watch && !cur_ok && other_ok && (low_cnt == 2'd3);

  // Count consecutive cycles the selected clock is missing while quiescent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      low_cnt <= 2'd0;
    end else if (!watch || cur_ok) begin
      low_cnt <= 2'd0;
    end else if (low_cnt != 2'd3) begin
      low_cnt <= low_cnt + 2'd1;
    end
  end
`else
  assign failover_hit = 1'b0;
`endif

  // Next-state and registered-output logic for the switch sequence.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    select_n    = select;
    target_n    = target;
    id_n        = id;
    fo_active_n = fo_active;
    done_n      = 1'b0;
    err_n       = 1'b0;
    resp_id_n   = resp_id;
    err_code_n  = 2'b00;
    case (state)
      S_IDLE: begin
        if (failover_hit) begin
          state_n     = S_SWITCH;
          target_n    = ~select;
          fo_active_n = 1'b1;
          cnt_n       = '0;
        end else if (grant0 || grant1) begin
          target_n = acc_sel;
          id_n     = acc_id;
          if (acc_sel == select) begin
            done_n    = 1'b1;
            resp_id_n = acc_id;
          end else begin
            state_n = S_CHECK;
            cnt_n   = '0;
          end
        end
      end
      S_CHECK: begin
        if (target_ok) begin
          state_n = S_SWITCH;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n    = S_IDLE;
          cnt_n      = '0;
          err_n      = 1'b1;
          err_code_n = ERR_TIMEOUT;
          resp_id_n  = id;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_SWITCH: begin
        select_n = target;
        cnt_n    = '0;
        state_n  = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_n = S_DWELL;
          cnt_n   = '0;
          if (fo_active) begin
            err_n       = 1'b1;
            err_code_n  = ERR_FAILOVER;
            resp_id_n   = 1'b0;
            fo_active_n = 1'b0;
          end else begin
            done_n    = 1'b1;
            resp_id_n = id;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_DWELL: begin
        if (failover_hit) begin
          state_n     = S_SWITCH;
          target_n    = ~select;
          fo_active_n = 1'b1;
          cnt_n       = '0;
        end else if (cnt == DWELL_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State register; reset abandons any in-flight request without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      select    <= RESET_SEL;
      target    <= RESET_SEL;
      id        <= 1'b0;
      fo_active <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      resp_id   <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      select    <= select_n;
      target    <= target_n;
      id        <= id_n;
      fo_active <= fo_active_n;
      done      <= done_n;
      err       <= err_n;
      resp_id   <= resp_id_n;
      err_code  <= err_code_n;
    end
  end

endmodule

// File: tb/tb_clk_switch_sequencer.sv
// tb/tb_clk_switch_sequencer.sv - scoreboard bench for clk_switch_sequencer
module tb_clk_switch_sequencer;

  localparam int S = 16;
  localparam int D = 64;
  localparam int T = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req0_sel = 1'b0;
  logic       req1_valid = 1'b0, req1_sel = 1'b0;
  logic       clk1_ok = 1'b1, clk2_ok = 1'b1;
  logic       req0_ready, req1_ready, select, busy, done, err, resp_id;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int id;
    int code;
    int cyc;
  } exp_t;

  exp_t q[$];

  clk_switch_sequencer dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_ready(req1_ready),
    .clk1_ok(clk1_ok), .clk2_ok(clk2_ok),
    .select(select), .busy(busy), .done(done), .err(err),
    .resp_id(resp_id), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int kind, input int id, input int code, input int at);
    exp_t e;
    e.kind = kind; e.id = id; e.code = code; e.cyc = at;
    q.push_back(e);
  endtask

  // Response monitor: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (done && err) check_eq("done_err_excl", 1, 0);
      if (done || err) begin
        if (q.size() == 0) begin
          check_eq("unexpected_resp", 1, 0);
        end else begin
          e = q.pop_front();
          check_eq("resp_kind", {31'd0, err}, e.kind);
          check_eq("resp_id", {31'd0, resp_id}, e.id);
          if (err) check_eq("err_code", {30'd0, err_code}, e.code);
          check_eq("resp_cyc", cyc, e.cyc);
        end
      end
    end
  end

  // Caller has just driven valid at a negedge; poll until this requester is granted.
  task automatic wait_ready(input int n, output bit got);
    got = 1'b0;
    for (int t = 0; t < 600; t++) begin
      #1;
      if ((n == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check_eq("accept_timeout", 0, 1);
    if (got) check_eq("one_ready", {31'd0, req0_ready & req1_ready}, 0);
  endtask

  // kind: 0 = done, 1 = err, 2 = no response expected. lat = edges after accept edge.
  task automatic do_req(input int n, input bit sel, input int kind, input int lat,
                        input int code, output int acc);
    bit got;
    @(negedge clk);
    if (n == 0) begin req0_valid = 1'b1; req0_sel = sel; end
    else        begin req1_valid = 1'b1; req1_sel = sel; end
    wait_ready(n, got);
    acc = cyc;
    if (got && kind < 2) push_exp(kind, n, code, acc + 1 + lat);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("idle_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a1, a2, acc0, c0;
    bit got;

    // Reset values, with a request pending to prove ready is held low.
    req1_valid = 1'b1; req1_sel = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_select", {31'd0, select}, 1);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_done", {31'd0, done}, 0);
    check_eq("rst_err", {31'd0, err}, 0);
    check_eq("rst_ready1", {31'd0, req1_ready}, 0);
    check_eq("rst_resp_id", {31'd0, resp_id}, 0);
    check_eq("rst_err_code", {30'd0, err_code}, 0);
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Same-target request: immediate done, no switch.
    do_req(1, 1'b1, 0, 0, 0, a);
    @(negedge clk);
    check_eq("t1_busy", {31'd0, busy}, 0);
    check_eq("t1_select", {31'd0, select}, 1);
    wait_idle();

    // Switching request: select after 2 edges, done at 2+S, dwell blocks until 2+S+D.
    do_req(0, 1'b0, 0, 2 + S, 0, a);
    @(negedge clk);
    @(negedge clk);
    check_eq("t2_sel_hold", {31'd0, select}, 1);
    @(negedge clk);
    check_eq("t2_sel_toggle", {31'd0, select}, 0);
    check_eq("t2_busy", {31'd0, busy}, 1);
    req1_valid = 1'b1; req1_sel = 1'b0;
    wait_ready(1, got);
    check_eq("t2_dwell_accept_cyc", cyc, a + 3 + S + D);
    if (got) push_exp(0, 1, 0, cyc + 1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_idle();

    // Timeout in CHECK, then immediate re-accept.
    clk1_ok = 1'b0;
    do_req(1, 1'b1, 1, T, 1, a1);
    do_req(0, 1'b0, 0, 0, 0, a2);
    check_eq("t3_reaccept_cyc", a2, a1 + 1 + T);
    check_eq("t3_select", {31'd0, select}, 0);
    wait_idle();
    clk1_ok = 1'b1;

    // Simultaneous requests: req0 first, req1 after req0's dwell.
    @(negedge clk);
    req0_valid = 1'b1; req0_sel = 1'b1;
    req1_valid = 1'b1; req1_sel = 1'b0;
    #1;
    check_eq("t4_ready0", {31'd0, req0_ready}, 1);
    check_eq("t4_ready1", {31'd0, req1_ready}, 0);
    acc0 = cyc;
    push_exp(0, 0, 0, acc0 + 3 + S);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    wait_ready(1, got);
    check_eq("t4_req1_accept_cyc", cyc, acc0 + 3 + S + D);
    if (got) push_exp(0, 1, 0, cyc + 3 + S);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_idle();
    check_eq("t4_select", {31'd0, select}, 0);

    // Reset mid-SETTLE: select snaps back, no response.
    do_req(0, 1'b1, 0, 2 + S, 0, a);
    wait_idle();
    do_req(1, 1'b0, 2, 0, 0, a);
    repeat (8) @(negedge clk);
    check_eq("t5_sel_settle", {31'd0, select}, 0);
    #2 rst = 1'b0;
    #1;
    check_eq("t5_rst_async_sel", {31'd0, select}, 1);
    check_eq("t5_rst_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (S + 10) @(negedge clk);
    check_eq("t5_busy_after", {31'd0, busy}, 0);
    check_eq("t5_sel_after", {31'd0, select}, 1);

    // Selected clock disappears while idle.
    @(negedge clk);
    clk1_ok = 1'b0;
    c0 = cyc;
`ifdef AUTO_FAILOVER_EN
    push_exp(1, 0, 2, c0 + 5 + S);
    repeat (4) @(negedge clk);
    check_eq("t6_sel_before", {31'd0, select}, 1);
    @(negedge clk);
    check_eq("t6_sel_failover", {31'd0, select}, 0);
    wait_idle();
`else
    repeat (30) @(negedge clk);
    check_eq("t6_sel_kept", {31'd0, select}, 1);
    check_eq("t6_busy", {31'd0, busy}, 0);
`endif
    clk1_ok = 1'b1;

    repeat (5) @(negedge clk);
    check_eq("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_switch_sequencer.md
Name: clk_switch_sequencer

Overview:
Control-plane sequencer for the glitch-free clock switch. Runs on an always-on reference clock and takes clock-source requests from two requesters: req0 is the power manager (high priority), req1 is the software CSR. It checks that the target clock is present, drives the switch `select`, waits a settle period, then enforces a minimum dwell before the next switch. It reports completion or error back to the granted requester.

Parameters:
CNT_W, 8, width of the shared cycle counter.
SETTLE_CYCLES, 16, cycles held in SETTLE after `select` changes; legal range 1..2^CNT_W-1.
DWELL_CYCLES, 64, cycles held in DWELL after settle before the next request is accepted; legal range 1..2^CNT_W-1.
TIMEOUT_CYCLES, 200, maximum cycles to wait in CHECK for the target clock's `ok`; legal range 1..2^CNT_W-1.
RESET_SEL, 1, reset value of `select` (1 = clk_1, 0 = clk_2).

Ports:
clk  in  1  reference clock; one clock only.
rst  in  1  asynchronous, active-low reset.
req0_valid  in  1  power-manager switch request.
req0_sel  in  1  requested source for req0 (1 = clk_1, 0 = clk_2).
req0_ready  out  1  accept strobe for req0.
req1_valid  in  1  software switch request.
req1_sel  in  1  requested source for req1.
req1_ready  out  1  accept strobe for req1.
clk1_ok  in  1  clk_1 present, already synchronised to clk.
clk2_ok  in  1  clk_2 present, already synchronised to clk.
select  out  1  drives the switch select input.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse: the accepted request completed.
err  out  1  one-cycle pulse: the accepted request failed.
resp_id  out  1  requester the done/err pulse belongs to; valid while done or err is high.
err_code  out  2  valid with err: 01 = timeout, 10 = failover (optional feature only).

Behaviour:
- Reset values: select=RESET_SEL, state=IDLE, counter=0, all readies/done/err/busy=0, resp_id=0, err_code=0. Reset acts asynchronously mid-operation: the FSM returns to IDLE, select returns to RESET_SEL, and any in-flight request is dropped with no response.
- States: IDLE, CHECK, SWITCH, SETTLE, DWELL.
- Arbitration in IDLE: fixed priority, req0 over req1. reqN_ready is combinational and is high only in IDLE, only for the granted requester. Accept occurs on valid&ready; target and id are latched at accept. The requester holds valid and sel until accepted. Only one ready is high per cycle.
- Accept with target == select: no switch. done and resp_id are issued in the next cycle, the FSM stays in IDLE, and no dwell applies.
- Accept with target != select: go to CHECK and set counter=0.
- CHECK: if the target's ok is high, go to SWITCH. Otherwise increment the counter. When counter == TIMEOUT_CYCLES-1 with ok still low: pulse err with err_code=01, leave select unchanged, return to IDLE (no dwell).
- SWITCH: one cycle. select <= target, counter=0, go to SETTLE.
- SETTLE: exit after exactly SETTLE_CYCLES cycles. On exit pulse done with resp_id, set counter=0, go to DWELL.
- DWELL: readies held low for DWELL_CYCLES cycles, then return to IDLE.
- Latencies for a switching request, measured from the accept edge:
  - select toggles 2 cycles after accept (target ok already high, so CHECK lasts 1 cycle).
  - done occurs 2+SETTLE_CYCLES cycles after accept.
  - The next accept is possible 2+SETTLE_CYCLES+DWELL_CYCLES cycles after accept.
- Counter never wraps. Every compare is against a parameter minus 1, and the counter is cleared on each state entry.
- Simultaneous valid on both requesters: req0 wins; req1 keeps waiting.
- Requests arriving while busy are not accepted, and their ready stays low.
- A target ok that drops after CHECK has passed does not abort the sequence.
- done and err are never high in the same cycle.

Optional Feature:
AUTO_FAILOVER_EN:
- Defined: in IDLE or DWELL, if the ok for the currently selected clock is low for 4 consecutive cycles and the other clock's ok is high, the controller switches autonomously:
  - goes directly to SWITCH toward the other clock, abandoning any remaining dwell;
  - on exit from SETTLE it pulses err with err_code=10 and resp_id=0 (no done pulse);
  - it then proceeds through DWELL as for a normal switch.
  - If a requester accept and the failover condition occur in the same IDLE cycle, the failover takes precedence and ready stays low.
- Undefined: no autonomous action; err_code=10 is never produced.

Test Plan:
1. Reset with RESET_SEL=1, release; req1_valid=1, req1_sel=1 -> req1_ready in cycle 0, done with resp_id=1 one cycle later, select stays 1, busy stays 0.
2. clk2_ok=1, req0_valid with req0_sel=0 -> select=0 two cycles after accept; done with resp_id=0 at 2+16; both readies low until 2+16+64.
3. clk1_ok=0, select=0, req1_sel=1 -> after 200 cycles in CHECK, err with err_code=01 and resp_id=1; select stays 0; next request accepted immediately.
4. req0 and req1 both valid in the same IDLE cycle with differing sel -> req0_ready high and req1_ready low; req1 accepted only after req0 completes and the dwell expires.
5. Assert rst mid-SETTLE -> select returns to RESET_SEL asynchronously; no done pulse; FSM in IDLE after release.
6. With AUTO_FAILOVER_EN defined, select=1 and clk1_ok dropped for 4 cycles while clk2_ok=1 -> select=0, then err with err_code=10 after 16 settle cycles; without the macro, select stays 1.
